// File: rtl/jk_cnt_pkg.sv
// rtl/jk_cnt_pkg.sv - shared JK codes, operation select and excitation function
//
// Purpose : constants and helpers shared by the JK counter and its per-bit stage.
//   HOLD/CLR/SET/TOG : 2-bit {j,k} codes of a JK flop
//   cnt_op_e         : per-edge operation chosen by the counter
//   jk_excite()      : (present, next) -> {j,k}, every case resolved
// Optional build macro used by the counter: JK_COUNTER_UPDOWN_EN
package jk_cnt_pkg;

  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] CLR  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TOG  = 2'b11;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_RESET = 2'd3
  } cnt_op_e;

  // Excitation with don't-cares pinned: a bit that keeps its value gets
  // HOLD, never TOG/CLR/SET, so the stage input is fully determined.
  function automatic logic [1:0] jk_excite(input logic present, input logic next);
    logic [1:0] jk;
    case ({present, next})
      2'b00:   jk = HOLD;
      2'b01:   jk = SET;
      2'b10:   jk = CLR;
      default: jk = HOLD;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cnt_stage.sv
// rtl/jk_cnt_stage.sv - one JK flip-flop stage, falling-edge, sync active-high reset
//
// Purpose : holds one count bit; 00 hold, 01 clear, 10 set, 11 toggle.
// Ports   :
//   clk_i : clock, state changes on the falling edge
//   rst_i : synchronous active-high reset, forces q to 0
//   j, k  : JK control inputs
//   q     : stored bit
module jk_cnt_stage
  import jk_cnt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    case ({j, k})
      HOLD:    q_d = q_q;
      CLR:     q_d = 1'b0;
      SET:     q_d = 1'b1;
      TOG:     q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/jk_down_counter.sv
// rtl/jk_down_counter.sv - modulo-N down counter built from JK stages
//
// Purpose : counts MODULUS-1 .. 0 and wraps, with clamped parallel load.
//   The desired next count is formed in binary, then each bit is turned into
//   J/K by excitation of (present, next) and applied to a jk_cnt_stage.
// Parameters:
//   WIDTH   : counter width in bits
//   MODULUS : count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
// Ports   :
//   clk_i      : clock, all state changes on the falling edge
//   rst_i      : synchronous active-high reset (highest priority)
//   en_i       : count enable
//   load_i     : parallel-load strobe (beats en_i)
//   load_val_i : load value, clamped to MODULUS-1
//   dir_up_i   : count direction, 1 = up (only with JK_COUNTER_UPDOWN_EN)
//   count_o    : present count, straight from the stages
//   tc_o       : terminal count, high on the edge that will wrap
//   zero_o     : count_o == 0
// Build macro: JK_COUNTER_UPDOWN_EN adds dir_up_i and up-counting.
module jk_down_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
`ifdef JK_COUNTER_UPDOWN_EN
  input  logic             dir_up_i,
`endif
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             zero_o
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is still representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] count_step;
  logic             at_zero;
  logic             step_wraps;
  cnt_op_e          op;

  assign at_zero = (count_q == '0);

  always_comb begin
    load_clamped = load_val_i;
    if ({1'b0, load_val_i} >= MOD_EXT) begin
      load_clamped = MAX_CNT;
    end
  end

`ifdef JK_COUNTER_UPDOWN_EN
  logic at_max;
  // >= rather than == so an out-of-range count would still fall back to 0.
  assign at_max = (count_q >= MAX_CNT);

  always_comb begin
    count_step = count_q;
    step_wraps = 1'b0;
    if (dir_up_i) begin
      step_wraps = at_max;
      count_step = at_max ? '0 : count_q + WIDTH'(1);
    end else begin
      step_wraps = at_zero;
      count_step = at_zero ? MAX_CNT : count_q - WIDTH'(1);
    end
  end
`else
  always_comb begin
    step_wraps = at_zero;
    count_step = at_zero ? MAX_CNT : count_q - WIDTH'(1);
  end
`endif

  always_comb begin
    op = OP_HOLD;
    if (rst_i) begin
      op = OP_RESET;
    end else if (load_i) begin
      op = OP_LOAD;
    end else if (en_i) begin
      op = OP_COUNT;
    end
  end

  always_comb begin
    count_d = count_q;
    case (op)
      OP_RESET: count_d = '0;
      OP_LOAD:  count_d = load_clamped;
      OP_COUNT: count_d = count_step;
      OP_HOLD:  count_d = count_q;
      default:  count_d = count_q;
    endcase
  end

  // Reset is also applied inside each stage, so the J/K values on a reset
  // edge do not matter; they still point at 0 to keep the two paths aligned.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic [1:0] jk;
    assign jk = jk_excite(count_q[i], count_d[i]);

    jk_cnt_stage u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .j     (jk[1]),
      .k     (jk[0]),
      .q     (count_q[i])
    );
  end

  assign count_o = count_q;
  assign zero_o  = at_zero;
  assign tc_o    = en_i & ~load_i & step_wraps;

endmodule

// File: tb/tb_jk_down_counter.sv
// tb/tb_jk_down_counter.sv - self-checking bench for jk_down_counter
module tb_jk_down_counter;

  localparam int W   = 4;
  localparam int MOD = 10;

  logic         clk;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] lv;
  logic         dir_up;
  logic [W-1:0] count;
  logic         tc;
  logic         zero;

  int total;
  int bad;
  int m;

  jk_down_counter #(.WIDTH(W), .MODULUS(MOD)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (lv),
`ifdef JK_COUNTER_UPDOWN_EN
    .dir_up_i   (dir_up),
`endif
    .count_o    (count),
    .tc_o       (tc),
    .zero_o     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change half a cycle away from the active (falling) edge.
  task automatic drive(input logic r, input logic l, input logic [W-1:0] v, input logic e);
    @(posedge clk);
    rst  = r;
    load = l;
    lv   = v;
    en   = e;
    #1;
  endtask

  // Advance one falling edge and step the reference model.
  task automatic tick();
    @(negedge clk);
    #1;
    if (rst) m = 0;
    else if (load) m = (int'(lv) >= MOD) ? MOD - 1 : int'(lv);
    else if (en) m = dir_up ? (m + 1) % MOD : (m + MOD - 1) % MOD;
  endtask

  function automatic logic model_tc();
    if (!en || load) return 1'b0;
    return dir_up ? (m == MOD - 1) : (m == 0);
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'd7, 1'b1);
    tick();
    drive(1'b1, 1'b1, 4'd7, 1'b1);
    tick();
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d want=0", count);
    end
    total++;
    if (zero !== 1'b1) begin
      bad++;
      $display("FAIL reset_zero got=%b want=1", zero);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0);
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_tc_idle got=%b want=0", tc);
    end
    drive(1'b1, 1'b0, 4'd0, 1'b1);
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL reset_tc_en got=%b want=1", tc);
    end
    tick();
    m = 0;
  endtask

  task automatic test_wrap();
    int seq [12] = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
    int prev;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 4'd0, 1'b1);
      total++;
      if (tc !== (prev == 0)) begin
        bad++;
        $display("FAIL wrap_tc step=%0d got=%b want=%b", i, tc, (prev == 0));
      end
      tick();
      total++;
      if (count !== W'(seq[i])) begin
        bad++;
        $display("FAIL wrap_count step=%0d got=%0d want=%0d", i, count, seq[i]);
      end
      total++;
      if (zero !== (seq[i] == 0)) begin
        bad++;
        $display("FAIL wrap_zero step=%0d got=%b want=%b", i, zero, (seq[i] == 0));
      end
      prev = seq[i];
    end
  endtask

  task automatic test_load_clamp();
    int vals [7] = '{5, 13, 9, 10, 15, 0, 2};
    int want [7] = '{5, 9, 9, 9, 9, 0, 2};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, W'(vals[i]), 1'b0);
      tick();
      total++;
      if (count !== W'(want[i])) begin
        bad++;
        $display("FAIL load_clamp val=%0d got=%0d want=%0d", vals[i], count, want[i]);
      end
    end
  endtask

  task automatic test_load_and_enable();
    drive(1'b0, 1'b1, 4'd6, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'd3, 1'b1);
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL load_en_tc got=%b want=0", tc);
    end
    tick();
    total++;
    if (count !== 4'd3) begin
      bad++;
      $display("FAIL load_en_count got=%0d want=3", count);
    end
    drive(1'b0, 1'b1, 4'd0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 4'd7, 1'b1);
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL load_en_tc_at0 got=%b want=0", tc);
    end
    tick();
    total++;
    if (count !== 4'd7) begin
      bad++;
      $display("FAIL load_en_count_at0 got=%0d want=7", count);
    end
  endtask

  task automatic test_hold_reset();
    drive(1'b0, 1'b1, 4'd4, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, W'($urandom_range(15)), 1'b0);
      tick();
      total++;
      if (count !== 4'd4) begin
        bad++;
        $display("FAIL hold step=%0d got=%0d want=4", i, count);
      end
    end
    drive(1'b1, 1'b0, 4'd0, 1'b1);
    tick();
    total++;
    if (count !== 4'd0 || zero !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset got=%0d/%b want=0/1", count, zero);
    end
  endtask

`ifdef JK_COUNTER_UPDOWN_EN
  task automatic test_updown();
    dir_up = 1'b0;
    drive(1'b0, 1'b1, 4'd8, 1'b0);
    tick();
    dir_up = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    tick();
    total++;
    if (count !== 4'd9) begin
      bad++;
      $display("FAIL up_to9 got=%0d want=9", count);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL up_tc got=%b want=1", tc);
    end
    tick();
    total++;
    if (count !== 4'd0) begin
      bad++;
      $display("FAIL up_wrap got=%0d want=0", count);
    end
    dir_up = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 1'b1);
    total++;
    if (tc !== 1'b1) begin
      bad++;
      $display("FAIL down_tc got=%b want=1", tc);
    end
    tick();
    total++;
    if (count !== 4'd9) begin
      bad++;
      $display("FAIL down_wrap got=%0d want=9", count);
    end
  endtask
`endif

  task automatic test_random();
    logic exp_tc;
    for (int i = 0; i < 400; i++) begin
`ifdef JK_COUNTER_UPDOWN_EN
      dir_up = 1'($urandom_range(1));
`endif
      drive(($urandom_range(15) == 0), ($urandom_range(3) == 0),
            W'($urandom_range(15)), 1'($urandom_range(1)));
      exp_tc = model_tc();
      total++;
      if (tc !== exp_tc) begin
        bad++;
        $display("FAIL rand_tc i=%0d got=%b want=%b", i, tc, exp_tc);
      end
      tick();
      total++;
      if (count !== W'(m) || zero !== (m == 0)) begin
        bad++;
        $display("FAIL rand_count i=%0d got=%0d/%b want=%0d/%b", i, count, zero, m, (m == 0));
      end
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    m      = 0;
    rst    = 1'b1;
    en     = 1'b0;
    load   = 1'b0;
    lv     = '0;
    dir_up = 1'b0;
    test_reset();
    test_wrap();
    test_load_clamp();
    test_load_and_enable();
    test_hold_reset();
`ifdef JK_COUNTER_UPDOWN_EN
    test_updown();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
